// File: rtl/adc_sar_sequencer_if.sv
// Result hand-off bundle between the SAR sequencer and its consumer:
// single-entry valid/ready buffer plus the sticky overrun flag.
interface adc_sar_sequencer_if #(
    parameter int RESOLUTION = 8
);
    logic [RESOLUTION-1:0] result;
    logic                  result_valid;
    logic                  result_ready;
    logic                  overrun;

    modport master (
        output result,
        output result_valid,
        output overrun,
        input  result_ready
    );

    modport slave (
        input  result,
        input  result_valid,
        input  overrun,
        output result_ready
    );
endinterface

// File: rtl/adc_sar_sequencer.sv
// SAR conversion sequencer: request detection, sampling window, one bit resolved
// per clk_dig cycle from the comparator, and a single-entry result buffer.
module adc_sar_sequencer #(
    parameter int RESOLUTION    = 8,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic                  clk_dig,
    input  logic                  rst,
    input  logic                  ena_in,
    input  logic                  start_conv,
    input  logic                  comp_in,
    output logic                  sample,
    output logic [RESOLUTION-1:0] dac_code,
    output logic                  busy,
    adc_sar_sequencer_if.master   res_if
);

    localparam int CNT_W = $clog2(SAMPLE_CYCLES + 1);
    localparam int IDX_W = $clog2(RESOLUTION);
    localparam logic [RESOLUTION-1:0] MSB_TRIAL = {1'b1, {(RESOLUTION-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONVERT
    } state_t;

    state_t                state_reg;
    logic                  start_q_reg;
    logic [CNT_W-1:0]      sample_cnt_reg;
    logic [IDX_W-1:0]      bit_idx_reg;
    logic [RESOLUTION-1:0] code_reg;
    logic                  sample_reg;
    logic                  busy_reg;
    logic [RESOLUTION-1:0] result_reg;
    logic                  result_valid_reg;
    logic                  overrun_reg;

    logic                  trigger;
    logic                  transfer;
    logic [RESOLUTION-1:0] code_step;

    assign trigger  = (start_conv & ~start_q_reg) | ena_in;
    assign transfer = result_valid_reg & res_if.result_ready;

    // Code after the current decision: bit i takes the comparator result and,
    // unless this is the last bit, bit i-1 becomes the next trial bit.
    for (genvar gi = 0; gi < RESOLUTION; gi++) begin : g_code_step
        assign code_step[gi] = (32'(bit_idx_reg) == gi)     ? comp_in :
                               (32'(bit_idx_reg) == gi + 1) ? 1'b1    :
                                                              code_reg[gi];
    end

    always_ff @(posedge clk_dig) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            start_q_reg      <= 1'b0;
            sample_cnt_reg   <= '0;
            bit_idx_reg      <= '0;
            code_reg         <= '0;
            sample_reg       <= 1'b0;
            busy_reg         <= 1'b0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            start_q_reg <= start_conv;

            // A load later in this block overrides the clear, so a same-cycle
            // load and transfer leaves the buffer full without overrun.
            if (transfer) begin
                result_valid_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    code_reg <= '0;
                    if (trigger) begin
                        state_reg      <= ST_SAMPLE;
                        sample_reg     <= 1'b1;
                        busy_reg       <= 1'b1;
                        sample_cnt_reg <= CNT_W'(SAMPLE_CYCLES - 1);
                    end
                end

                ST_SAMPLE: begin
                    if (sample_cnt_reg == '0) begin
                        state_reg   <= ST_CONVERT;
                        sample_reg  <= 1'b0;
                        code_reg    <= MSB_TRIAL;
                        bit_idx_reg <= IDX_W'(RESOLUTION - 1);
                    end else begin
                        sample_cnt_reg <= sample_cnt_reg - CNT_W'(1);
                    end
                end

                ST_CONVERT: begin
                    if (bit_idx_reg == '0) begin
                        state_reg        <= ST_IDLE;
                        busy_reg         <= 1'b0;
                        code_reg         <= '0;
                        result_reg       <= code_step;
                        result_valid_reg <= 1'b1;
                        if (result_valid_reg && !res_if.result_ready) begin
                            overrun_reg <= 1'b1;
                        end
                    end else begin
                        code_reg    <= code_step;
                        bit_idx_reg <= bit_idx_reg - IDX_W'(1);
                    end
                end

                default: begin
                    state_reg  <= ST_IDLE;
                    sample_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                    code_reg   <= '0;
                end
            endcase
        end
    end

    assign sample              = sample_reg;
    assign dac_code            = code_reg;
    assign busy                = busy_reg;
    assign res_if.result       = result_reg;
    assign res_if.result_valid = result_valid_reg;
    assign res_if.overrun      = overrun_reg;

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Directed bench for adc_sar_sequencer: expected results are queued when a
// conversion is requested and popped by a monitor whenever a result is loaded.
module tb_adc_sar_sequencer;

    localparam int RES = 8;
    localparam int SC  = 2;

    logic           clk_dig = 1'b0;
    logic           rst;
    logic           ena_in;
    logic           start_conv;
    logic           comp_in;
    logic           sample;
    logic [RES-1:0] dac_code;
    logic           busy;

    logic [RES-1:0] target;
    int             comp_sel;   // 0: comparator model, 1: constant 1, 2: constant 0

    adc_sar_sequencer_if #(.RESOLUTION(RES)) res_if ();

    adc_sar_sequencer #(
        .RESOLUTION   (RES),
        .SAMPLE_CYCLES(SC)
    ) dut (
        .clk_dig   (clk_dig),
        .rst       (rst),
        .ena_in    (ena_in),
        .start_conv(start_conv),
        .comp_in   (comp_in),
        .sample    (sample),
        .dac_code  (dac_code),
        .busy      (busy),
        .res_if    (res_if)
    );

    always #5 clk_dig = ~clk_dig;

    assign comp_in = (comp_sel == 1) ? 1'b1 :
                     (comp_sel == 2) ? 1'b0 : (target >= dac_code);

    typedef struct {
        logic [RES-1:0] res;
        logic           ovr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [RES-1:0] a5_seq [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a busy fall not caused by rst is a buffer load.
    initial begin
        logic busy_prev;
        logic rst_edge;
        exp_t e;
        busy_prev = 1'b0;
        forever begin
            @(posedge clk_dig);
            rst_edge = rst;
            @(negedge clk_dig);
            if (!rst_edge && busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(res_if.result), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    $display("result 0x%02h valid %0b overrun %0b (expected 0x%02h / %0b)",
                             res_if.result, res_if.result_valid, res_if.overrun, e.res, e.ovr);
                    check("result", 32'(res_if.result), 32'(e.res));
                    check("result_valid_on_load", 32'(res_if.result_valid), 32'd1);
                    check("overrun_on_load", 32'(res_if.overrun), 32'(e.ovr));
                end
            end
            busy_prev = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One start_conv pulse; n counts edges after E0, sampled at the negedge.
    task automatic run_single(input logic [RES-1:0] tgt, input int sel,
                              input bit chk_seq, input bit inject_edge);
        exp_t e;
        target   = tgt;
        comp_sel = sel;
        e.res = tgt;
        e.ovr = 1'b0;
        exp_q.push_back(e);
        start_conv = 1'b1;
        @(posedge clk_dig);
        #1 start_conv = 1'b0;
        for (int n = 0; n <= 10; n++) begin
            @(negedge clk_dig);
            if (n == 0) begin
                check("busy_after_E0", 32'(busy), 32'd1);
                check("sample_after_E0", 32'(sample), 32'd1);
            end
            if (n == SC - 1) check("sample_last", 32'(sample), 32'd1);
            if (n == SC) begin
                check("sample_fall", 32'(sample), 32'd0);
                check("dac_msb_trial", 32'(dac_code), 32'h80);
            end
            if (chk_seq && n >= 2 && n <= 9) check("dac_seq", 32'(dac_code), 32'(a5_seq[n-2]));
            if (inject_edge && n == 4) start_conv = 1'b1;
            if (inject_edge && n == 5) start_conv = 1'b0;
            if (n == 9) check("busy_before_load", 32'(busy), 32'd1);
            if (n == 10) begin
                check("busy_fall", 32'(busy), 32'd0);
                check("result_valid_E10", 32'(res_if.result_valid), 32'd1);
                check("dac_zero_idle", 32'(dac_code), 32'd0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_dig);
            check("no_second_conv", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        exp_t e;
        a5_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        rst = 1'b1;
        ena_in = 1'b0;
        start_conv = 1'b0;
        target = '0;
        comp_sel = 0;
        res_if.result_ready = 1'b1;

        // Reset held two cycles while start_conv toggles.
        @(posedge clk_dig);
        #1 start_conv = 1'b1;
        @(posedge clk_dig);
        #1 start_conv = 1'b0;
        @(negedge clk_dig);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_dac", 32'(dac_code), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(res_if.result), 32'd0);
        check("rst_valid", 32'(res_if.result_valid), 32'd0);
        check("rst_overrun", 32'(res_if.overrun), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_dig);
            check("idle_after_rst", 32'(busy), 32'd0);
        end

        // Single conversion and the two extremes.
        run_single(8'hA5, 0, 1'b1, 1'b0);
        run_single(8'hFF, 1, 1'b0, 1'b0);
        run_single(8'h00, 2, 1'b0, 1'b0);

        // Continuous mode: three conversions, each accepted on the cycle it appears.
        target = 8'h3C;
        comp_sel = 0;
        e.res = 8'h3C;
        e.ovr = 1'b0;
        for (int k = 0; k < 3; k++) exp_q.push_back(e);
        ena_in = 1'b1;
        for (int n = 0; n <= 32; n++) begin
            @(negedge clk_dig);
            check("cont_busy", 32'(busy), 32'((n % 11) != 10));
            check("cont_valid", 32'(res_if.result_valid), 32'((n % 11) == 10));
            if (n == 22) ena_in = 1'b0;
        end
        check("cont_overrun", 32'(res_if.overrun), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_dig);
            check("cont_stopped", 32'(busy), 32'd0);
        end

        // Overrun: no consumer, then ready only on the third load cycle.
        res_if.result_ready = 1'b0;
        target = 8'h5A;
        e.res = 8'h5A; e.ovr = 1'b0; exp_q.push_back(e);
        e.res = 8'h33; e.ovr = 1'b1; exp_q.push_back(e);
        e.res = 8'h77; e.ovr = 1'b1; exp_q.push_back(e);
        ena_in = 1'b1;
        for (int n = 0; n <= 32; n++) begin
            @(negedge clk_dig);
            if (n == 10) begin
                check("ovr_first_valid", 32'(res_if.result_valid), 32'd1);
                check("ovr_first_flag", 32'(res_if.overrun), 32'd0);
                target = 8'h33;
            end
            if (n == 21) begin
                check("ovr_second_flag", 32'(res_if.overrun), 32'd1);
                target = 8'h77;
            end
            if (n == 22) ena_in = 1'b0;
            if (n == 31) res_if.result_ready = 1'b1;
            if (n == 32) begin
                res_if.result_ready = 1'b0;
                check("ovr_load_xfer_valid", 32'(res_if.result_valid), 32'd1);
                check("ovr_sticky", 32'(res_if.overrun), 32'd1);
            end
        end
        for (int k = 0; k < 3; k++) @(negedge clk_dig);
        check("ovr_still_set", 32'(res_if.overrun), 32'd1);
        check("ovr_valid_held", 32'(res_if.result_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk_dig);
        rst = 1'b0;
        check("ovr_cleared_by_rst", 32'(res_if.overrun), 32'd0);
        check("valid_cleared_by_rst", 32'(res_if.result_valid), 32'd0);
        check("result_cleared_by_rst", 32'(res_if.result), 32'd0);

        // Start edge during CONVERT is ignored; buffer left full for the abort test.
        run_single(8'hA5, 0, 1'b0, 1'b1);

        // Abort with rst while bit 4 is being resolved.
        start_conv = 1'b1;
        @(posedge clk_dig);
        #1 start_conv = 1'b0;
        for (int n = 0; n <= 5; n++) begin
            @(negedge clk_dig);
            if (n == 5) rst = 1'b1;
        end
        @(negedge clk_dig);
        rst = 1'b0;
        check("abort_dac", 32'(dac_code), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(res_if.result_valid), 32'd0);
        check("abort_sample", 32'(sample), 32'd0);

        res_if.result_ready = 1'b1;
        run_single(8'h5C, 0, 1'b0, 1'b0);

        @(negedge clk_dig);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_sar_sequencer.md
# adc_sar_sequencer

Synchronous successive-approximation sequencer for the SAR ADC digital back end. Detects a conversion request (start_conv rising edge, or free-running when ena_in is high), drives the sampling switch, then resolves one bit per clk_dig cycle from the comparator decision and updates the capacitive DAC code. The finished code goes into a single-entry valid/ready output buffer with overrun flagging. Sits between the clock generator/comparator and the system bus interface.

## Interface
- RESOLUTION, 8: conversion bits; legal 2..16.
- SAMPLE_CYCLES, 2: cycles sample stays high; legal 1..15.

- clk_dig  input  1  digital SAR clock; all state updates on rising edge.
- rst  input  1  reset; one clock, synchronous and active-high.
- ena_in  input  1  continuous-conversion enable; level.
- start_conv  input  1  single-conversion request; rising edge triggers.
- comp_in  input  1  comparator decision; 1 means input >= current dac_code.
- sample  output  1  sampling switch control; high during SAMPLE.
- dac_code  output  RESOLUTION  DAC trial code.
- busy  output  1  high in SAMPLE or CONVERT.
- result  output  RESOLUTION  buffered conversion result.
- result_valid  output  1  result buffer holds unread data.
- result_ready  input  1  consumer accepts result when result_valid and result_ready are both high.
- overrun  output  1  sticky; an unread result was overwritten.

## Operation
- Reset values: state IDLE, sample=0, dac_code=0, busy=0, result=0, result_valid=0, overrun=0, start_q=0.
- start_q registers start_conv every cycle. edge = start_conv & ~start_q.
- States: IDLE, SAMPLE, CONVERT.
- IDLE -> SAMPLE when edge or ena_in. Otherwise stay in IDLE. dac_code=0.
- SAMPLE: sample=1, dac_code=0. After SAMPLE_CYCLES cycles -> CONVERT with bit index i=RESOLUTION-1.
- CONVERT, bit i: dac_code = decided upper bits, then bit i = 1, then lower bits 0.
  - At the clock edge, bit i = comp_in and i decrements.
  - After bit 0: the final code loads into result, state -> IDLE, sample=0, dac_code=0.
- Requests while busy (edges or ena_in) are ignored, not queued. ena_in falling mid-conversion does not abort.
- Output buffer:
  - Transfer occurs on any cycle with result_valid & result_ready; it clears result_valid unless a load happens the same cycle.
  - Load with buffer empty: result_valid=1.
  - Load and transfer in the same cycle: new result loaded, result_valid stays 1, no overrun.
  - Load with result_valid=1 and no transfer: result overwritten, overrun set.
  - overrun is cleared only by rst.
- rst mid-conversion: all registers return to reset values at that edge; the partial result is discarded.
- Counters: sample counter ceil(log2(SAMPLE_CYCLES+1)) bits; bit index ceil(log2(RESOLUTION)) bits. Neither wraps; each is reloaded on state entry.

## Timing
- Edge E0 is the edge that samples start_conv=1 with start_q=0 (or ena_in=1) in IDLE.
- sample and busy rise after E0 and stay high for SAMPLE_CYCLES cycles.
- After E(SAMPLE_CYCLES): sample=0, dac_code = 1<<(RESOLUTION-1).
- comp_in is sampled at edges E(SAMPLE_CYCLES+1) .. E(SAMPLE_CYCLES+RESOLUTION).
- result and result_valid update after E(SAMPLE_CYCLES+RESOLUTION); busy falls at the same edge.
- Defaults: result_valid rises 10 cycles after E0.
- Continuous mode: one IDLE cycle between conversions, giving a period of SAMPLE_CYCLES+RESOLUTION+1 cycles (11 at defaults).
- comp_in must be stable before the rising edge. It is used unregistered within one cycle of dac_code changing; the comparator path budget is one clk_dig period.

## Test plan
- Reset: hold rst 2 cycles while start_conv toggles -> all outputs 0; busy stays 0.
- Single conversion with comparator model comp_in = (0xA5 >= dac_code), one start_conv pulse, ena_in=0:
  - dac_code sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - result=0xA5, result_valid 10 cycles after E0.
  - No second conversion.
- Extremes: comp_in constant 1 -> result 0xFF; comp_in constant 0 -> result 0x00.
- Continuous mode, ena_in=1, result_ready=1, input code 0x3C:
  - busy drops for exactly one cycle every 11 cycles.
  - Each result 0x3C, accepted on the cycle it appears; overrun stays 0.
- Overrun: ena_in=1, result_ready=0 -> second result overwrites the first and overrun=1.
  - Then assert result_ready exactly on a load cycle -> valid stays 1, overrun stays 1 until rst.
- Ignored and aborted requests:
  - start_conv edge during CONVERT -> no extra conversion.
  - rst asserted at bit 4 -> dac_code=0, busy=0, result_valid=0 next cycle.
  - Next start -> full 10-cycle conversion.
